// File: rtl/sram_resp_model.sv
// On-board stand-in for the external SRAM behind sram_ctrl: storage array, read pipeline,
// post-reset clear sweep, saturating access counters and a sticky protocol-error checker.
module sram_resp_model #(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       ADDR_W   = 10,
   parameter int unsigned       RD_LAT   = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              s_cen,
   input  logic              s_wen,
   input  logic              s_oen,
   input  logic [ADDR_W-1:0] s_addr,
   input  logic [DATA_W-1:0] s_ddata,
   output logic [DATA_W-1:0] s_qdata,
   input  logic              err_clr,
   output logic              ready,
   output logic [31:0]       wr_cnt,
   output logic [31:0]       rd_cnt,
   output logic              err_flag,
   output logic [1:0]        err_code
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = 32;
   localparam int unsigned ERR_W = 2;
   localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ERR_W-1:0]  ERR_INIT = 2'b01;
   localparam logic [ERR_W-1:0]  ERR_CONF = 2'b10;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] qdata_q, qdata_d;
   logic              pipe_vld_q, pipe_vld_d;
   logic [DATA_W-1:0] pipe_data_q, pipe_data_d;
   logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
   logic              err_flag_q, err_flag_d;
   logic [ERR_W-1:0]  err_code_q, err_code_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              acc_req;
   logic              new_err;
   logic [ERR_W-1:0]  new_code;

   // Next-state decode: sweep in INIT, pin-protocol service in RUN
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      ready_d     = ready_q;
      qdata_d     = qdata_q;
      pipe_vld_d  = 1'b0;
      pipe_data_d = pipe_data_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      err_flag_d  = err_flag_q;
      err_code_d  = err_code_q;
      mem_we      = 1'b0;
      mem_waddr   = s_addr;
      mem_wdata   = s_ddata;
      new_err     = 1'b0;
      new_code    = '0;
      acc_req     = !s_cen && (!s_wen || !s_oen);

      case (state_q)
         ST_INIT: begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = INIT_VAL;
            ptr_d     = ptr_q + ADDR_W'(1);
            if (ptr_q == PTR_LAST) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end
            if (acc_req) begin
               new_err  = 1'b1;
               new_code = ERR_INIT;
            end
         end
         ST_RUN: begin
            if (!s_cen && !s_wen) begin
               mem_we   = 1'b1;
               wr_cnt_d = (wr_cnt_q == '1) ? wr_cnt_q : wr_cnt_q + CNT_W'(1);
               if (!s_oen) begin
                  new_err  = 1'b1;
                  new_code = ERR_CONF;
               end
            end else if (!s_cen && !s_oen) begin
               rd_cnt_d = (rd_cnt_q == '1) ? rd_cnt_q : rd_cnt_q + CNT_W'(1);
               if (RD_LAT == 1) begin
                  qdata_d = mem_q[s_addr];
               end else begin
                  pipe_vld_d  = 1'b1;
                  pipe_data_d = mem_q[s_addr];
               end
            end
         end
         default: state_d = ST_INIT;
      endcase

      // Second read stage; only populated when RD_LAT is 2
      if (RD_LAT != 1 && pipe_vld_q) begin
         qdata_d = pipe_data_q;
      end

      // First error sticks; a clear coinciding with a new error yields the new one
      if (new_err) begin
         err_flag_d = 1'b1;
         err_code_d = (err_flag_q && !err_clr) ? err_code_q : new_code;
      end else if (err_clr) begin
         err_flag_d = 1'b0;
         err_code_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_INIT;
         ptr_q       <= '0;
         ready_q     <= 1'b0;
         qdata_q     <= '0;
         pipe_vld_q  <= 1'b0;
         pipe_data_q <= '0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         err_flag_q  <= 1'b0;
         err_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         ready_q     <= ready_d;
         qdata_q     <= qdata_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_data_q <= pipe_data_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         err_flag_q  <= err_flag_d;
         err_code_q  <= err_code_d;
      end
   end

   // Storage array has no reset; contents are cleared by the INIT sweep
   always_ff @(posedge clk) begin
      if (reset_n && mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   assign s_qdata  = qdata_q;
   assign ready    = ready_q;
   assign wr_cnt   = wr_cnt_q;
   assign rd_cnt   = rd_cnt_q;
   assign err_flag = err_flag_q;
   assign err_code = err_code_q;

endmodule

// File: tb/tb_sram_resp_model.sv
// Directed bench for sram_resp_model: two instances (read latency 1 and 2) share the pin stimulus.
module tb_sram_resp_model;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       s_cen, s_wen, s_oen, err_clr;
   logic [9:0] s_addr;
   logic [7:0] s_ddata;

   logic [7:0]  q1, q2;
   logic        rdy1, rdy2, ef1, ef2;
   logic [31:0] wc1, wc2, rc1, rc2;
   logic [1:0]  ec1, ec2;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sram_resp_model #(.DATA_W(8), .ADDR_W(10), .RD_LAT(1), .INIT_VAL(8'h00)) dut1 (
      .clk(clk), .reset_n(reset_n), .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen),
      .s_addr(s_addr), .s_ddata(s_ddata), .s_qdata(q1), .err_clr(err_clr),
      .ready(rdy1), .wr_cnt(wc1), .rd_cnt(rc1), .err_flag(ef1), .err_code(ec1));

   sram_resp_model #(.DATA_W(8), .ADDR_W(10), .RD_LAT(2), .INIT_VAL(8'h00)) dut2 (
      .clk(clk), .reset_n(reset_n), .s_cen(s_cen), .s_wen(s_wen), .s_oen(s_oen),
      .s_addr(s_addr), .s_ddata(s_ddata), .s_qdata(q2), .err_clr(err_clr),
      .ready(rdy2), .wr_cnt(wc2), .rd_cnt(rc2), .err_flag(ef2), .err_code(ec2));

   typedef struct {
      logic        cen, wen, oen, clr;
      logic [9:0]  addr;
      logic [7:0]  data;
      logic [7:0]  q1, q2;
      logic [31:0] wr, rd;
      logic        flag;
      logic [1:0]  code;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic cen, wen, oen, clr, input logic [9:0] addr,
                               input logic [7:0] data, eq1, eq2, input int wr, rd,
                               input logic flag, input logic [1:0] code);
      vec_t v;
      v.cen = cen; v.wen = wen; v.oen = oen; v.clr = clr;
      v.addr = addr; v.data = data; v.q1 = eq1; v.q2 = eq2;
      v.wr = 32'(wr); v.rd = 32'(rd); v.flag = flag; v.code = code;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic cen, wen, oen, input logic [9:0] addr, input logic [7:0] data);
      s_cen = cen; s_wen = wen; s_oen = oen; s_addr = addr; s_ddata = data;
   endtask

   task automatic idle();
      drive(1'b1, 1'b1, 1'b1, 10'h000, 8'h00);
   endtask

   task automatic chk_both_err(input string nm, input logic flag, input logic [1:0] code);
      chk({nm, "_flag1"}, 32'(ef1), 32'(flag));
      chk({nm, "_flag2"}, 32'(ef2), 32'(flag));
      chk({nm, "_code1"}, 32'(ec1), 32'(code));
      chk({nm, "_code2"}, 32'(ec2), 32'(code));
   endtask

   // Counts edges from the current point until ready is seen, bounded
   task automatic wait_ready(input int start, output int n);
      n = start;
      do begin
         step();
         n++;
      end while (!rdy1 && n < 2000);
   endtask

   int n;

   initial begin
      vecs[0]  = mk(0,1,0,0, 10'h000, 8'h00, 8'h00, 8'h00, 1, 1, 0, 2'b00);
      vecs[1]  = mk(0,1,0,0, 10'h3FF, 8'h00, 8'h00, 8'h00, 1, 2, 0, 2'b00);
      vecs[2]  = mk(0,0,1,0, 10'h155, 8'hA5, 8'h00, 8'h00, 2, 2, 0, 2'b00);
      vecs[3]  = mk(0,1,0,0, 10'h155, 8'h00, 8'hA5, 8'h00, 2, 3, 0, 2'b00);
      vecs[4]  = mk(1,1,1,0, 10'h000, 8'h00, 8'hA5, 8'hA5, 2, 3, 0, 2'b00);
      vecs[5]  = mk(0,0,0,0, 10'h010, 8'h3C, 8'hA5, 8'hA5, 3, 3, 1, 2'b10);
      vecs[6]  = mk(0,1,0,0, 10'h010, 8'h00, 8'h3C, 8'hA5, 3, 4, 1, 2'b10);
      vecs[7]  = mk(0,1,1,1, 10'h010, 8'h00, 8'h3C, 8'h3C, 3, 4, 0, 2'b00);
      vecs[8]  = mk(0,0,0,0, 10'h011, 8'h77, 8'h3C, 8'h3C, 4, 4, 1, 2'b10);
      vecs[9]  = mk(0,0,0,1, 10'h012, 8'h88, 8'h3C, 8'h3C, 5, 4, 1, 2'b10);
      vecs[10] = mk(0,1,0,0, 10'h011, 8'h00, 8'h77, 8'h3C, 5, 5, 1, 2'b10);
      vecs[11] = mk(0,1,0,0, 10'h012, 8'h00, 8'h88, 8'h77, 5, 6, 1, 2'b10);
      vecs[12] = mk(1,1,1,1, 10'h000, 8'h00, 8'h88, 8'h88, 5, 6, 0, 2'b00);

      reset_n = 1'b0;
      err_clr = 1'b0;
      idle();
      step();
      step();
      chk("rst_q1", 32'(q1), 32'h0);
      chk("rst_q2", 32'(q2), 32'h0);
      chk("rst_ready", 32'({rdy1, rdy2}), 32'h0);
      chk("rst_wr", wc1 | wc2, 32'h0);
      chk("rst_rd", rc1 | rc2, 32'h0);
      chk_both_err("rst", 1'b0, 2'b00);

      // Sweep with an access attempted at INIT edge 5
      reset_n = 1'b1;
      for (int i = 1; i <= 4; i++) step();
      drive(1'b0, 1'b0, 1'b1, 10'h000, 8'hA5);
      step();
      idle();
      chk_both_err("init_acc", 1'b1, 2'b01);
      chk("init_acc_wr", wc1 | wc2, 32'h0);
      chk("init_ready", 32'({rdy1, rdy2}), 32'h0);
      wait_ready(5, n);
      chk("sweep_len", 32'(n), 32'd1024);
      chk("ready2", 32'(rdy2), 32'h1);

      // A conflict after INIT must not overwrite the first error code
      drive(1'b0, 1'b0, 1'b0, 10'h020, 8'h11);
      step();
      idle();
      chk_both_err("first_err", 1'b1, 2'b01);
      chk("first_err_rd", rc1, 32'h0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk_both_err("clr", 1'b0, 2'b00);

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].cen, vecs[i].wen, vecs[i].oen, vecs[i].addr, vecs[i].data);
         err_clr = vecs[i].clr;
         step();
         chk($sformatf("v%0d_q1", i), 32'(q1), 32'(vecs[i].q1));
         chk($sformatf("v%0d_q2", i), 32'(q2), 32'(vecs[i].q2));
         chk($sformatf("v%0d_wr", i), wc1, vecs[i].wr);
         chk($sformatf("v%0d_wr2", i), wc2, vecs[i].wr);
         chk($sformatf("v%0d_rd", i), rc1, vecs[i].rd);
         chk($sformatf("v%0d_rd2", i), rc2, vecs[i].rd);
         chk($sformatf("v%0d_flag", i), 32'(ef1), 32'(vecs[i].flag));
         chk($sformatf("v%0d_code", i), 32'(ec2), 32'(vecs[i].code));
      end
      err_clr = 1'b0;
      idle();

      // Full-array write sweep then back-to-back read-back
      for (int a = 0; a < 1024; a++) begin
         logic [9:0] ad;
         ad = 10'(a);
         drive(1'b0, 1'b1, 1'b1, ad, ad[7:0]);
         s_wen = 1'b0;
         step();
      end
      chk("sweep_wr", wc1, 32'd1029);
      for (int a = 0; a < 1024; a++) begin
         logic [9:0] ad;
         logic [9:0] pa;
         ad = 10'(a);
         pa = 10'(a - 1);
         drive(1'b0, 1'b1, 1'b0, ad, 8'h00);
         step();
         chk($sformatf("rb1_%0h", a), 32'(q1), 32'(ad[7:0]));
         if (a > 0) chk($sformatf("rb2_%0h", a), 32'(q2), 32'(pa[7:0]));
      end
      idle();
      step();
      chk("rb2_last", 32'(q2), 32'h000000FF);
      chk("sweep_rd1", rc1, 32'd1030);
      chk("sweep_rd2", rc2, 32'd1030);
      chk("sweep_wr2", wc2, 32'd1029);

      // Reset in the middle of a read stream after an error
      for (int a = 0; a < 3; a++) begin
         drive(1'b0, 1'b1, 1'b0, 10'(a + 5), 8'h00);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 10'h155, 8'h99);
      step();
      chk("pre_rst_flag", 32'(ef1), 32'h1);
      drive(1'b0, 1'b1, 1'b0, 10'h003, 8'h00);
      reset_n = 1'b0;
      step();
      chk("mid_rst_q1", 32'(q1), 32'h0);
      chk("mid_rst_q2", 32'(q2), 32'h0);
      chk("mid_rst_cnt", wc1 | rc1 | wc2 | rc2, 32'h0);
      chk("mid_rst_ready", 32'({rdy1, rdy2}), 32'h0);
      chk_both_err("mid_rst", 1'b0, 2'b00);
      step();
      step();
      chk("rst_hold_q2", 32'(q2), 32'h0);
      idle();
      reset_n = 1'b1;
      wait_ready(0, n);
      chk("resweep_len", 32'(n), 32'd1024);
      drive(1'b0, 1'b1, 1'b0, 10'h155, 8'h00);
      step();
      chk("resweep_155", 32'(q1), 32'h0);
      drive(1'b0, 1'b1, 1'b0, 10'h001, 8'h00);
      step();
      chk("resweep_001", 32'(q1), 32'h0);
      chk("resweep_155_l2", 32'(q2), 32'h0);
      idle();
      step();
      chk("resweep_001_l2", 32'(q2), 32'h0);
      chk("resweep_rd", rc1, 32'd2);

      // Counter saturation from a forced preload
      force dut1.wr_cnt_d = 32'hFFFF_FFFF;
      force dut1.rd_cnt_d = 32'hFFFF_FFFF;
      step();
      release dut1.wr_cnt_d;
      release dut1.rd_cnt_d;
      drive(1'b0, 1'b0, 1'b1, 10'h200, 8'h01);
      #1;
      chk("preload_wr", wc1, 32'hFFFF_FFFF);
      step();
      chk("sat_wr", wc1, 32'hFFFF_FFFF);
      drive(1'b0, 1'b1, 1'b0, 10'h200, 8'h00);
      step();
      chk("sat_rd", rc1, 32'hFFFF_FFFF);
      chk("sat_rd_q", 32'(q1), 32'h01);
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
